// File: rtl/execute_stage.sv
// EX stage with EX/MEM pipeline register: integer ALU, load/store address
// generation, single-cycle RV32M multiply and a 32-step iterative divider.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } alu_ctrl_e;
endpackage

module execute_stage
  import riscv_pkg::*;
#(
  parameter int DIV_STEPS = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            validE_i,
  input  logic            flushE_i,
  input  logic [XLEN-1:0] pcE_i,
  input  logic [XLEN-1:0] instrE_i,
  input  alu_ctrl_e       operationE_i,
  input  logic [XLEN-1:0] rs1E_data_i,
  input  logic [XLEN-1:0] rs2E_data_i,
  input  logic [XLEN-1:0] immE_i,
  input  logic            useImmE_i,
  input  logic [4:0]      rdE_addr_i,
  input  logic            rdE_wr_ena_i,
  input  logic            tb_update_i,
  output logic            stallE_o,
  output logic [XLEN-1:0] pcE_o,
  output logic [XLEN-1:0] instrE_o,
  output alu_ctrl_e       operationE_o,
  output logic [XLEN-1:0] rdE_data_o,
  output logic [4:0]      rdE_addr_o,
  output logic            rdE_wr_ena_o,
  output logic            memE_wrt_ena_o,
  output logic [XLEN-1:0] memE_addr_o,
  output logic [XLEN-1:0] memE_wrt_data_o,
  output logic            tb_update_o
);

  localparam int              CW        = $clog2(DIV_STEPS);
  localparam logic [CW-1:0]   LAST_STEP = CW'(DIV_STEPS - 1);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  div_state_e r_state, w_state_next;

  // EX/MEM register
  logic [XLEN-1:0] r_pc, r_instr, r_rd_data, r_mem_addr, r_mem_wdata;
  alu_ctrl_e       r_op;
  logic [4:0]      r_rd_addr;
  logic            r_rd_wr, r_mem_wr, r_tb;

  // divider state and latched pipeline fields of the divide in flight
  logic [XLEN-1:0] r_quot, r_rem, r_divisor;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r, r_is_rem;
  logic [XLEN-1:0] r_l_pc, r_l_instr;
  alu_ctrl_e       r_l_op;
  logic [4:0]      r_l_rd_addr;
  logic            r_l_rd_wr, r_l_tb;

  logic [XLEN-1:0]   w_b, w_sum, w_addr, w_alu;
  logic [4:0]        w_shamt;
  logic              w_is_store, w_is_div, w_div_signed;
  logic              w_mul_a_sgn, w_mul_b_sgn;
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic              w_neg_a, w_neg_b;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [XLEN:0]     w_rem_shift, w_diff;
  logic              w_step_ok;
  logic [XLEN-1:0]   w_q_fix, w_r_fix, w_div_result;
  logic              w_ld_normal, w_ld_bubble, w_ld_div, w_div_start, w_div_step;

  assign w_b        = useImmE_i ? immE_i : rs2E_data_i;
  assign w_shamt    = w_b[4:0];
  assign w_sum      = rs1E_data_i + w_b;
  assign w_addr     = rs1E_data_i + immE_i;
  assign w_is_store = (operationE_i == OP_SB) || (operationE_i == OP_SH) || (operationE_i == OP_SW);
  assign w_is_div   = (operationE_i == OP_DIV) || (operationE_i == OP_DIVU) ||
                      (operationE_i == OP_REM) || (operationE_i == OP_REMU);

  // One 64x64 multiplier; sign-extending each operand selects the MULH flavour.
  assign w_mul_a_sgn = (operationE_i == OP_MULH) || (operationE_i == OP_MULHSU);
  assign w_mul_b_sgn = (operationE_i == OP_MULH);
  assign w_mul_a     = {{XLEN{w_mul_a_sgn & rs1E_data_i[XLEN-1]}}, rs1E_data_i};
  assign w_mul_b     = {{XLEN{w_mul_b_sgn & w_b[XLEN-1]}}, w_b};
  assign w_prod      = w_mul_a * w_mul_b;

  always_comb begin
    w_alu = w_sum;
    case (operationE_i)
      OP_SUB:    w_alu = rs1E_data_i - w_b;
      OP_AND:    w_alu = rs1E_data_i & w_b;
      OP_OR:     w_alu = rs1E_data_i | w_b;
      OP_XOR:    w_alu = rs1E_data_i ^ w_b;
      OP_SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(rs1E_data_i) < $signed(w_b)};
      OP_SLTU:   w_alu = {{(XLEN-1){1'b0}}, rs1E_data_i < w_b};
      OP_SLL:    w_alu = rs1E_data_i << w_shamt;
      OP_SRL:    w_alu = rs1E_data_i >> w_shamt;
      OP_SRA:    w_alu = $signed(rs1E_data_i) >>> w_shamt;
      OP_MUL:    w_alu = w_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  w_alu = w_prod[2*XLEN-1:XLEN];
      default:   w_alu = w_sum;
    endcase
  end

  assign w_div_signed = (operationE_i == OP_DIV) || (operationE_i == OP_REM);
  assign w_neg_a      = w_div_signed & rs1E_data_i[XLEN-1];
  assign w_neg_b      = w_div_signed & w_b[XLEN-1];
  assign w_abs_a      = w_neg_a ? -rs1E_data_i : rs1E_data_i;
  assign w_abs_b      = w_neg_b ? -w_b : w_b;

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_divisor};
  assign w_step_ok   = ~w_diff[XLEN];

  // A zero divisor leaves |A| in the remainder, so only the quotient needs overriding.
  assign w_q_fix      = (r_divisor == '0) ? '1 : (r_neg_q ? -r_quot : r_quot);
  assign w_r_fix      = r_neg_r ? -r_rem : r_rem;
  assign w_div_result = r_is_rem ? w_r_fix : w_q_fix;

  always_comb begin
    w_state_next = r_state;
    stallE_o     = 1'b0;
    w_ld_normal  = 1'b0;
    w_ld_bubble  = 1'b0;
    w_ld_div     = 1'b0;
    w_div_start  = 1'b0;
    w_div_step   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (validE_i && !flushE_i && w_is_div) begin
          w_div_start  = 1'b1;
          stallE_o     = 1'b1;
          w_ld_bubble  = 1'b1;
          w_state_next = S_BUSY;
        end else if (validE_i && !flushE_i) begin
          w_ld_normal = 1'b1;
        end else begin
          w_ld_bubble = 1'b1;
        end
      end
      S_BUSY: begin
        w_ld_bubble = 1'b1;
        if (flushE_i) begin
          w_state_next = S_IDLE;
        end else begin
          stallE_o   = 1'b1;
          w_div_step = 1'b1;
          if (r_cnt == LAST_STEP) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        if (flushE_i) w_ld_bubble = 1'b1;
        else          w_ld_div    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_rem    <= 1'b0;
      r_l_pc      <= '0;
      r_l_instr   <= NOP_INSTR;
      r_l_op      <= OP_ADD;
      r_l_rd_addr <= '0;
      r_l_rd_wr   <= 1'b0;
      r_l_tb      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_div_start) begin
        r_quot      <= w_abs_a;
        r_rem       <= '0;
        r_divisor   <= w_abs_b;
        r_cnt       <= '0;
        r_neg_q     <= w_neg_a ^ w_neg_b;
        r_neg_r     <= w_neg_a;
        r_is_rem    <= (operationE_i == OP_REM) || (operationE_i == OP_REMU);
        r_l_pc      <= pcE_i;
        r_l_instr   <= instrE_i;
        r_l_op      <= operationE_i;
        r_l_rd_addr <= rdE_addr_i;
        r_l_rd_wr   <= rdE_wr_ena_i;
        r_l_tb      <= tb_update_i;
      end else if (w_div_step) begin
        r_rem  <= w_step_ok ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], w_step_ok};
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Bubbles only rewrite the control fields; pc and data hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_op        <= OP_ADD;
      r_rd_data   <= '0;
      r_rd_addr   <= '0;
      r_rd_wr     <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tb        <= 1'b0;
    end else if (w_ld_normal) begin
      r_pc        <= pcE_i;
      r_instr     <= instrE_i;
      r_op        <= operationE_i;
      r_rd_data   <= w_alu;
      r_rd_addr   <= rdE_addr_i;
      r_rd_wr     <= rdE_wr_ena_i & ~w_is_store;
      r_mem_wr    <= w_is_store;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= rs2E_data_i;
      r_tb        <= tb_update_i;
    end else if (w_ld_div) begin
      r_pc      <= r_l_pc;
      r_instr   <= r_l_instr;
      r_op      <= r_l_op;
      r_rd_data <= w_div_result;
      r_rd_addr <= r_l_rd_addr;
      r_rd_wr   <= r_l_rd_wr;
      r_mem_wr  <= 1'b0;
      r_tb      <= r_l_tb;
    end else if (w_ld_bubble) begin
      r_instr  <= NOP_INSTR;
      r_op     <= OP_ADD;
      r_rd_wr  <= 1'b0;
      r_mem_wr <= 1'b0;
      r_tb     <= 1'b0;
    end
  end

  assign pcE_o           = r_pc;
  assign instrE_o        = r_instr;
  assign operationE_o    = r_op;
  assign rdE_data_o      = r_rd_data;
  assign rdE_addr_o      = r_rd_addr;
  assign rdE_wr_ena_o    = r_rd_wr;
  assign memE_wrt_ena_o  = r_mem_wr;
  assign memE_addr_o     = r_mem_addr;
  assign memE_wrt_data_o = r_mem_wdata;
  assign tb_update_o     = r_tb;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for single-cycle ops,
// hand-written sequences for divides, flush and reset mid-divide.
module tb_execute_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        validE_i, flushE_i, useImmE_i, rdE_wr_ena_i, tb_update_i;
  logic [31:0] pcE_i, instrE_i, rs1E_data_i, rs2E_data_i, immE_i;
  alu_ctrl_e   operationE_i;
  logic [4:0]  rdE_addr_i;
  logic        stallE_o, rdE_wr_ena_o, memE_wrt_ena_o, tb_update_o;
  logic [31:0] pcE_o, instrE_o, rdE_data_o, memE_addr_o, memE_wrt_data_o;
  alu_ctrl_e   operationE_o;
  logic [4:0]  rdE_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk_i(clk), .rst_i(rst_i), .validE_i(validE_i), .flushE_i(flushE_i),
    .pcE_i(pcE_i), .instrE_i(instrE_i), .operationE_i(operationE_i),
    .rs1E_data_i(rs1E_data_i), .rs2E_data_i(rs2E_data_i), .immE_i(immE_i),
    .useImmE_i(useImmE_i), .rdE_addr_i(rdE_addr_i), .rdE_wr_ena_i(rdE_wr_ena_i),
    .tb_update_i(tb_update_i), .stallE_o(stallE_o), .pcE_o(pcE_o),
    .instrE_o(instrE_o), .operationE_o(operationE_o), .rdE_data_o(rdE_data_o),
    .rdE_addr_o(rdE_addr_o), .rdE_wr_ena_o(rdE_wr_ena_o),
    .memE_wrt_ena_o(memE_wrt_ena_o), .memE_addr_o(memE_addr_o),
    .memE_wrt_data_o(memE_wrt_data_o), .tb_update_o(tb_update_o)
  );

  typedef struct packed {
    logic        valid;
    logic        flush;
    alu_ctrl_e   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_rd_wr;
    logic        exp_mem_wr;
    logic [31:0] exp_addr;
    logic        chk_addr;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_ctrl_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] instr);
    validE_i     = 1'b1;
    flushE_i     = 1'b0;
    operationE_i = op;
    rs1E_data_i  = a;
    rs2E_data_i  = b;
    immE_i       = 32'h0;
    useImmE_i    = 1'b0;
    pcE_i        = pc;
    instrE_i     = instr;
    rdE_addr_i   = 5'd5;
    rdE_wr_ena_i = 1'b1;
    tb_update_i  = 1'b1;
  endtask

  // Called on a negedge; returns on the negedge where the result is visible.
  task automatic run_div(input string name, input alu_ctrl_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int   cnt;
    logic bub_bad;
    drive(op, a, b, 32'h0000_2000, 32'h0220_C2B3);
    cnt     = 0;
    bub_bad = 1'b0;
    #1;
    while (stallE_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
      if (instrE_o !== NOP || rdE_wr_ena_o !== 1'b0 || memE_wrt_ena_o !== 1'b0 ||
          tb_update_o !== 1'b0)
        bub_bad = 1'b1;
      #1;
    end
    chk({name, " stall_cycles"}, 32'(cnt), 32'd33);
    chk({name, " bubbles"}, {31'b0, bub_bad}, 32'h0);
    validE_i = 1'b0;
    @(negedge clk);
    chk({name, " result"}, rdE_data_o, exp);
    chk({name, " instr"}, instrE_o, 32'h0220_C2B3);
    chk({name, " pc"}, pcE_o, 32'h0000_2000);
    chk({name, " rd_wr"}, {31'b0, rdE_wr_ena_o}, 32'h1);
    chk({name, " tb_update"}, {31'b0, tb_update_o}, 32'h1);
    $display("div %s: a=%h b=%h result=%h stall_cycles=%0d", name, a, b, rdE_data_o, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           valid flush op         a             b             imm           ui   exp_data      cd   rw   mw   exp_addr      ca
    vecs[0]  = '{1'b1, 1'b0, OP_ADD,    32'h7FFF_FFFF, 32'h1,        32'h0,        1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, OP_SRA,    32'h8000_0000, 32'h0,        32'h24,       1'b1, 32'hF800_0000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, OP_SW,     32'h100,       32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'hFC,       1'b1};
    vecs[3]  = '{1'b1, 1'b0, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       1'b0, 32'h1,         1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, OP_SUB,    32'h5,         32'h7,        32'h0,        1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, OP_SLT,    32'hFFFF_FFFF, 32'h1,        32'h0,        1'b0, 32'h1,         1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 1'b0, OP_SLTU,   32'hFFFF_FFFF, 32'h1,        32'h0,        1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, OP_SLL,    32'h1,         32'h3F,       32'h0,        1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, OP_SRL,    32'h8000_0000, 32'h4,        32'h0,        1'b0, 32'h0800_0000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,       1'b0, 32'hF000_F000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, OP_OR,     32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,       1'b0, 32'hFFF0_FFF0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 1'b0, OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,       1'b0, 32'h0FF0_0FF0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{1'b1, 1'b0, OP_LW,     32'h1000,      32'h0,        32'h8,        1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h1008,     1'b1};
    vecs[16] = '{1'b0, 1'b0, OP_ADD,    32'h1,         32'h2,        32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[17] = '{1'b1, 1'b1, OP_SW,     32'h300,       32'h1234,     32'h4,        1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[18] = '{1'b1, 1'b0, OP_SB,     32'h200,       32'h55,       32'h1,        1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 32'h201,      1'b1};
    vecs[19] = '{1'b1, 1'b0, OP_ADD,    32'hA,         32'h63,       32'h5,        1'b1, 32'hF,         1'b1, 1'b1, 1'b0, 32'h0,        1'b0};

    rst_i = 1'b1;
    drive(OP_ADD, 32'h0, 32'h0, 32'h0, NOP);
    validE_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", pcE_o, 32'h8000_0000);
    chk("reset instr", instrE_o, NOP);
    chk("reset op", 32'(operationE_o), 32'(OP_ADD));
    chk("reset enables", {29'b0, rdE_wr_ena_o, memE_wrt_ena_o, tb_update_o}, 32'h0);
    chk("reset stall", {31'b0, stallE_o}, 32'h0);
    chk("reset data", rdE_data_o, 32'h0);
    rst_i = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      logic        bub;
      logic [31:0] pc, instr;
      pc    = 32'h0000_1000 + 32'(i * 4);
      instr = 32'h0100_0033 + 32'(i);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, pc, instr);
      validE_i   = vecs[i].valid;
      flushE_i   = vecs[i].flush;
      immE_i     = vecs[i].imm;
      useImmE_i  = vecs[i].use_imm;
      rdE_addr_i = 5'(i + 1);
      bub        = !vecs[i].valid || vecs[i].flush;
      #1;
      chk($sformatf("vec%0d stall", i), {31'b0, stallE_o}, 32'h0);
      @(negedge clk);
      chk($sformatf("vec%0d instr", i), instrE_o, bub ? NOP : instr);
      chk($sformatf("vec%0d rd_wr", i), {31'b0, rdE_wr_ena_o}, {31'b0, vecs[i].exp_rd_wr});
      chk($sformatf("vec%0d mem_wr", i), {31'b0, memE_wrt_ena_o}, {31'b0, vecs[i].exp_mem_wr});
      chk($sformatf("vec%0d tb_update", i), {31'b0, tb_update_o}, {31'b0, !bub});
      if (bub) begin
        chk($sformatf("vec%0d op", i), 32'(operationE_o), 32'(OP_ADD));
      end else begin
        chk($sformatf("vec%0d pc", i), pcE_o, pc);
        chk($sformatf("vec%0d rd_addr", i), {27'b0, rdE_addr_o}, 32'(i + 1));
        chk($sformatf("vec%0d op", i), 32'(operationE_o), 32'(vecs[i].op));
        chk($sformatf("vec%0d wdata", i), memE_wrt_data_o, vecs[i].b);
      end
      if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), rdE_data_o, vecs[i].exp_data);
      if (vecs[i].chk_addr) chk($sformatf("vec%0d addr", i), memE_addr_o, vecs[i].exp_addr);
      $display("vec %0d: op=%s a=%h b=%h imm=%h -> data=%h addr=%h rw=%b mw=%b",
               i, vecs[i].op.name(), vecs[i].a, vecs[i].b, vecs[i].imm,
               rdE_data_o, memE_addr_o, rdE_wr_ena_o, memE_wrt_ena_o);
    end

    run_div("div_-7/2",  OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD);
    run_div("rem_-7/2",  OP_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF);
    run_div("divu_5/0",  OP_DIVU, 32'h5,         32'h0,         32'hFFFF_FFFF);
    run_div("rem_5/0",   OP_REM,  32'h5,         32'h0,         32'h5);
    run_div("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("remu_100/7", OP_REMU, 32'd100,      32'd7,         32'd2);

    // Flush at BUSY counter 10 (11 cycles after the entry cycle)
    drive(OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'h0000_2000, 32'h0220_C2B3);
    repeat (11) @(negedge clk);
    flushE_i = 1'b1;
    #1;
    chk("flush stall_same_cycle", {31'b0, stallE_o}, 32'h0);
    @(negedge clk);
    drive(OP_ADD, 32'h3, 32'h4, 32'h0000_3000, 32'h0041_81B3);
    #1;
    chk("flush stall_next", {31'b0, stallE_o}, 32'h0);
    chk("flush bubble instr", instrE_o, NOP);
    chk("flush bubble rd_wr", {31'b0, rdE_wr_ena_o}, 32'h0);
    @(negedge clk);
    chk("post_flush add data", rdE_data_o, 32'h7);
    chk("post_flush add instr", instrE_o, 32'h0041_81B3);
    chk("post_flush add pc", pcE_o, 32'h0000_3000);
    $display("flush: post-flush ADD data=%h pc=%h", rdE_data_o, pcE_o);

    // Reset in the middle of a divide
    drive(OP_DIVU, 32'd1000, 32'd3, 32'h0000_4000, 32'h0220_D2B3);
    repeat (5) @(negedge clk);
    rst_i    = 1'b1;
    validE_i = 1'b0;
    @(negedge clk);
    chk("midrst pc", pcE_o, 32'h8000_0000);
    chk("midrst instr", instrE_o, NOP);
    chk("midrst data", rdE_data_o, 32'h0);
    chk("midrst stall", {31'b0, stallE_o}, 32'h0);
    rst_i = 1'b0;
    drive(OP_ADD, 32'h1, 32'h1, 32'h0000_5000, 32'h0010_80B3);
    #1;
    chk("post_rst stall", {31'b0, stallE_o}, 32'h0);
    @(negedge clk);
    chk("post_rst add data", rdE_data_o, 32'h2);
    $display("reset mid-divide: pc=%h post-reset ADD data=%h", pcE_o, rdE_data_o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
